// File: rtl/soc_bb_copy_master.sv
// soc_bb_copy_master
// Backbone bus initiator that either copies a block of words from one BB
// address range to another (COPY) or writes a constant pattern over a block
// (FILL). It is driven by a one-shot command interface and talks to a single
// BB slave port with a fixed one-cycle read latency.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start_i; BB bus quiet
// RD     | read request at src_ptr on the bus (COPY only)
// CAP    | bus quiet; slave read data captured into the write-data register
// WR     | write request at dst_ptr with captured data or the fill pattern
// DONE   | done_o high for this single cycle, then back to IDLE

module soc_bb_copy_master #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int LW = 16
) (
    input  logic          bb_clk_i,
    input  logic          bb_rst_i,

    input  logic          start_i,
    input  logic          mode_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [LW-1:0] len_i,
    input  logic [DW-1:0] fill_i,

    output logic          busy_o,
    output logic          done_o,
    output logic [LW-1:0] count_o,

    output logic [AW-1:0] bb_addr_o,
    output logic [DW-1:0] bb_dout_o,
    output logic          bb_en_o,
    output logic          bb_we_o,
    input  logic [DW-1:0] bb_din_i
);

    localparam int SW      = DW / 8;
    localparam int BYTE_AW = SW >> 1;

    // Address step per word and the mask that clears the byte-offset bits.
    localparam logic [AW-1:0] STEP       = AW'(SW);
    localparam logic [AW-1:0] ALIGN_MASK = ~((AW'(1) << BYTE_AW) - AW'(1));

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t        state;
    logic          mode_reg;
    logic [LW-1:0] len_reg;
    logic [DW-1:0] fill_reg;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;

    // Next-word values used when leaving WR.
    logic [LW-1:0] count_inc;
    logic [AW-1:0] src_inc;
    logic [AW-1:0] dst_inc;
    logic          last_word;

    // Pointer and counter increments; pointers wrap modulo 2^AW.
    always_comb begin
        count_inc = count_o + LW'(1);
        src_inc   = src_ptr + STEP;
        dst_inc   = dst_ptr + STEP;
        last_word = (count_inc == len_reg);
    end

    // Command sequencer. Every bus output is loaded on the edge that enters
    // the state it belongs to, so the outputs are registered and line up with
    // the state they describe.
    always_ff @(posedge bb_clk_i) begin
        if (bb_rst_i) begin
            state     <= S_IDLE;
            mode_reg  <= MODE_COPY;
            len_reg   <= '0;
            fill_reg  <= '0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            count_o   <= '0;
            bb_addr_o <= '0;
            bb_dout_o <= '0;
            bb_en_o   <= 1'b0;
            bb_we_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bb_en_o <= 1'b0;
                    bb_we_o <= 1'b0;
                    done_o  <= 1'b0;
                    if (start_i) begin
                        mode_reg <= mode_i;
                        len_reg  <= len_i;
                        fill_reg <= fill_i;
                        src_ptr  <= src_i & ALIGN_MASK;
                        dst_ptr  <= dst_i & ALIGN_MASK;
                        count_o  <= '0;
                        busy_o   <= 1'b1;
                        if (len_i == '0) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else if (mode_i == MODE_FILL) begin
                            state     <= S_WR;
                            bb_en_o   <= 1'b1;
                            bb_we_o   <= 1'b1;
                            bb_addr_o <= dst_i & ALIGN_MASK;
                            bb_dout_o <= fill_i;
                        end else begin
                            state     <= S_RD;
                            bb_en_o   <= 1'b1;
                            bb_we_o   <= 1'b0;
                            bb_addr_o <= src_i & ALIGN_MASK;
                        end
                    end
                end

                S_RD: begin
                    state   <= S_CAP;
                    bb_en_o <= 1'b0;
                    bb_we_o <= 1'b0;
                end

                S_CAP: begin
                    // Slave read data is valid in this cycle; it becomes the
                    // write data of the following WR.
                    state     <= S_WR;
                    bb_en_o   <= 1'b1;
                    bb_we_o   <= 1'b1;
                    bb_addr_o <= dst_ptr;
                    bb_dout_o <= bb_din_i;
                end

                S_WR: begin
                    src_ptr <= src_inc;
                    dst_ptr <= dst_inc;
                    count_o <= count_inc;
                    if (last_word) begin
                        state   <= S_DONE;
                        done_o  <= 1'b1;
                        bb_en_o <= 1'b0;
                        bb_we_o <= 1'b0;
                    end else if (mode_reg == MODE_FILL) begin
                        state     <= S_WR;
                        bb_en_o   <= 1'b1;
                        bb_we_o   <= 1'b1;
                        bb_addr_o <= dst_inc;
                        bb_dout_o <= fill_reg;
                    end else begin
                        state     <= S_RD;
                        bb_en_o   <= 1'b1;
                        bb_we_o   <= 1'b0;
                        bb_addr_o <= src_inc;
                    end
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    bb_en_o <= 1'b0;
                    bb_we_o <= 1'b0;
                end

                default: begin
                    state   <= S_IDLE;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    bb_en_o <= 1'b0;
                    bb_we_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bb_copy_master.sv
// Testbench for soc_bb_copy_master: a BB slave memory model, a queue of
// expected bus accesses filled by the stimulus, and a monitor that pops and
// compares every access the DUT issues.

module tb_soc_bb_copy_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic [DW-1:0] fill;
    logic          busy;
    logic          done;
    logic [LW-1:0] count;
    logic [AW-1:0] bb_addr;
    logic [DW-1:0] bb_dout;
    logic          bb_en;
    logic          bb_we;
    logic [DW-1:0] bb_din;

    soc_bb_copy_master #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .bb_clk_i  (clk),
        .bb_rst_i  (rst),
        .start_i   (start),
        .mode_i    (mode),
        .src_i     (src),
        .dst_i     (dst),
        .len_i     (len),
        .fill_i    (fill),
        .busy_o    (busy),
        .done_o    (done),
        .count_o   (count),
        .bb_addr_o (bb_addr),
        .bb_dout_o (bb_dout),
        .bb_en_o   (bb_en),
        .bb_we_o   (bb_we),
        .bb_din_i  (bb_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave memory model with one-cycle read latency and a preload port.
    logic [DW-1:0] mem [0:16383];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr[AW-1:2]] <= pre_data;
        else if (bb_en) begin
            if (bb_we)
                mem[bb_addr[AW-1:2]] <= bb_dout;
            else
                bb_din <= mem[bb_addr[AW-1:2]];
        end
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    acc_t exp_q[$];
    acc_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every enabled bus cycle must match the head of the queue.
    always @(negedge clk) begin
        if (bb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_access: got we=%0b addr=%0h expected none (t=%0t)",
                         bb_we, bb_addr, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("acc_we", 64'(bb_we), 64'(mon_e.we));
                chk("acc_addr", 64'(bb_addr), 64'(mon_e.addr));
                if (mon_e.we)
                    chk("acc_data", 64'(bb_dout), 64'(mon_e.data));
            end
        end
    end

    task automatic exp_rd(input logic [AW-1:0] a);
        acc_t e;
        e.we = 1'b0; e.addr = a; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_t e;
        e.we = 1'b1; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one command and wait for done_o; inj>0 asserts a second start
    // (to dst 0x500) at that cycle, which must be ignored.
    task automatic run_cmd(input string name, input logic m, input logic [AW-1:0] s,
                           input logic [AW-1:0] d, input logic [LW-1:0] l,
                           input logic [DW-1:0] f, input int exp_cyc,
                           input logic [LW-1:0] exp_cnt, input int inj);
        int got;
        got = -1;
        @(negedge clk);
        start = 1'b1; mode = m; src = s; dst = d; len = l; fill = f;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (done === 1'b1) begin
                got = n;
                break;
            end
            if (n == inj) begin
                start = 1'b1; mode = 1'b1; dst = 16'h0500; len = 16'd2;
            end
        end
        if (got < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_done_timeout: got no done expected done at cycle %0d", name, exp_cyc);
        end else begin
            chk({name, "_done_cycle"}, 64'(got), 64'(exp_cyc));
            chk({name, "_busy_at_done"}, 64'(busy), 64'd1);
            chk({name, "_count"}, 64'(count), 64'(exp_cnt));
            @(negedge clk);
            chk({name, "_done_pulse"}, 64'({busy, done}), 64'd0);
            chk({name, "_count_hold"}, 64'(count), 64'(exp_cnt));
        end
        chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; mode = 1'b0; src = 16'h0100; dst = 16'h0200;
        len = 16'd4; fill = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // Reset held with start asserted: nothing must happen.
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ctrl", 64'({busy, bb_en, done}), 64'd0);
            chk("rst_regs", 64'({count, bb_addr}), 64'd0);
            chk("rst_dout", 64'(bb_dout), 64'd0);
        end
        start = 1'b0;

        preload(16'h0100, 32'h11);
        preload(16'h0104, 32'h22);
        preload(16'h0108, 32'h33);
        preload(16'h010C, 32'h44);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // COPY basic.
        exp_rd(16'h0100); exp_wr(16'h0200, 32'h11);
        exp_rd(16'h0104); exp_wr(16'h0204, 32'h22);
        exp_rd(16'h0108); exp_wr(16'h0208, 32'h33);
        exp_rd(16'h010C); exp_wr(16'h020C, 32'h44);
        run_cmd("copy4", 1'b0, 16'h0100, 16'h0200, 16'd4, 32'h0, 13, 16'd4, 0);

        // FILL three words.
        exp_wr(16'h0040, 32'hDEADBEEF);
        exp_wr(16'h0044, 32'hDEADBEEF);
        exp_wr(16'h0048, 32'hDEADBEEF);
        run_cmd("fill3", 1'b1, 16'h0000, 16'h0040, 16'd3, 32'hDEADBEEF, 4, 16'd3, 0);

        // len = 0: no accesses, done next cycle.
        run_cmd("len0", 1'b0, 16'h0100, 16'h0200, 16'd0, 32'h0, 1, 16'd0, 0);

        // FILL across the top of the address space.
        exp_wr(16'hFFFC, 32'h5A5A5A5A);
        exp_wr(16'h0000, 32'h5A5A5A5A);
        run_cmd("fillwrap", 1'b1, 16'h0000, 16'hFFFC, 16'd2, 32'h5A5A5A5A, 3, 16'd2, 0);

        // Unaligned source and destination are word-aligned.
        exp_rd(16'h0100); exp_wr(16'h0300, 32'h11);
        run_cmd("unalign", 1'b0, 16'h0103, 16'h0302, 16'd1, 32'h0, 4, 16'd1, 0);

        // Second start while busy is ignored.
        exp_rd(16'h0100); exp_wr(16'h0400, 32'h11);
        exp_rd(16'h0104); exp_wr(16'h0404, 32'h22);
        run_cmd("busystart", 1'b0, 16'h0100, 16'h0400, 16'd2, 32'h0, 7, 16'd2, 3);

        // Reset during CAP of word 2 (cycle 5 after accept).
        exp_rd(16'h0100); exp_wr(16'h0600, 32'h11); exp_rd(16'h0104);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src = 16'h0100; dst = 16'h0600; len = 16'd4;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 5; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ctrl", 64'({busy, bb_en, done}), 64'd0);
        chk("midrst_count", 64'(count), 64'd0);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) @(negedge clk);
        chk("midrst_idle", 64'({busy, done}), 64'd0);
        chk("midrst_queue", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/soc_bb_copy_master.md
Name: soc_bb_copy_master

Overview:
- Backbone (BB) bus initiator that drives a BB slave port (e.g. a BB-wrapped single-port SRAM) from a simple command interface.
- Two modes:
  - COPY: reads LEN words starting at SRC and writes them to DST.
  - FILL: writes a constant pattern to LEN words at DST.
- Used for memory initialisation and block moves inside the tile, alongside the BB SRAM slaves on the same clock.

Parameters:
- AW, 16, BB byte-address width.
- DW, 32, data width; legal values 32, 16, 8.
- LW, 16, width of the word-count field.
- SW (local), DW/8, bytes per word.
- BYTE_AW (local), SW>>1, number of byte-offset address bits (2/1/0).

Ports:
- bb_clk_i  in  1  clock.
- bb_rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  command strobe; accepted only in IDLE.
- mode_i  in  1  0 = COPY, 1 = FILL; sampled at accept.
- src_i  in  AW  source byte address; sampled at accept.
- dst_i  in  AW  destination byte address; sampled at accept.
- len_i  in  LW  word count; sampled at accept.
- fill_i  in  DW  fill pattern; sampled at accept.
- busy_o  out  1  high from the cycle after accept until DONE is left.
- done_o  out  1  single-cycle completion pulse.
- count_o  out  LW  words written so far in the current/last command.
- bb_addr_o  out  AW  BB address.
- bb_dout_o  out  DW  BB write data (to slave bb_din_i).
- bb_en_o  out  1  BB access enable.
- bb_we_o  out  1  BB write enable.
- bb_din_i  in  DW  BB read data (from slave bb_dout_o); valid exactly 1 cycle after an en=1, we=0 cycle.

Behaviour:
- Clocking and reset: single clock, bb_clk_i. Reset is synchronous, active-high (bb_rst_i). All outputs are registered.
- Reset values: state=IDLE, busy_o=0, done_o=0, count_o=0, bb_en_o=0, bb_we_o=0, bb_addr_o=0, bb_dout_o=0.
- Reset mid-operation: the next edge forces IDLE and all outputs to reset values, and the command is dropped. Any slave read data returned afterwards is ignored.
- Accept: start_i=1 in IDLE latches mode/src/dst/len/fill and clears count_o.
  - The low BYTE_AW bits of src and dst are forced to 0 (word-aligned).
  - start_i in any other state is ignored; no queuing.
- len=0: IDLE -> DONE. No BB access; done_o pulses on the next cycle.
- States: IDLE, RD, CAP, WR, DONE.
  - IDLE -> RD (COPY) or WR (FILL) on accept with len != 0.
  - RD: bb_en_o=1, bb_we_o=0, bb_addr_o=src_ptr. Always -> CAP.
  - CAP: bb_en_o=0. data_reg <= bb_din_i. -> WR.
  - WR: bb_en_o=1, bb_we_o=1, bb_addr_o=dst_ptr, bb_dout_o=data_reg (COPY) or fill (FILL).
    - On exit from WR: src_ptr += SW, dst_ptr += SW, count_o += 1.
    - If count_o+1 == len -> DONE, else -> RD (COPY) or WR (FILL).
  - DONE: done_o=1 for exactly one cycle, busy_o=0 at the next edge. -> IDLE.
- Throughput: COPY takes 3 cycles per word; FILL takes 1 cycle per word (back-to-back WR).
  - Total cycles from accept edge to done_o high: COPY 3*len+1, FILL len+1.
- Address arithmetic: pointers are modulo 2^AW and wrap silently from max to 0. Overlapping src/dst ranges are not detected; copy proceeds in ascending order.
- bb_addr_o and bb_dout_o hold their last value when bb_en_o=0; slaves must ignore them.
- count_o holds its final value after DONE until the next accept.

Test Plan:
- Reset: assert bb_rst_i for 2 cycles with start_i=1 held -> busy_o=0, bb_en_o=0, done_o=0 throughout; no access issued.
- COPY basic:
  - Slave preloaded with words 0x100..0x10C = 11,22,33,44; src=0x100, dst=0x200, len=4.
  - Expect bus sequence RD 0x100, WR 0x200=11, ..., WR 0x20C=44.
  - done_o at cycle 13 after accept; count_o=4.
- FILL: dst=0x40, len=3, fill=0xDEADBEEF -> WR at 0x40, 0x44, 0x48 on consecutive cycles; done_o at cycle 4; no reads issued.
- Boundaries:
  - len=0 -> done_o next cycle, no bb_en_o.
  - AW=16, dst=0xFFFC, len=2 FILL -> writes 0xFFFC then 0x0000.
  - src=0x103 -> first read at 0x100.
- Start while busy: second start_i mid-COPY with different dst is ignored; only the first command's writes occur.
- Reset mid-COPY: reset during CAP of word 2 -> IDLE the next cycle, count_o=0, and no further bus accesses.
